// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: handshaked MEM pipeline stage between EXE and WB.
// Accepts one load/store/pass-through op at a time, drives a word-addressed
// data memory over a req/ack handshake, steers byte lanes, extends loads,
// flags misaligned accesses (adel/ades) and holds a registered result for WB.
// Optional feature: define MEM_TIMEOUT_EN to abort a memory request that has
// not been acknowledged within TIMEOUT cycles (bus_err pulse).
module mem_stage_ctrl #(
    parameter int WB_W    = 11,
    parameter int MADDR_W = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_read,
    input  logic               in_write,
    input  logic [1:0]         in_len,
    input  logic               in_unsigned,
    input  logic [WB_W-1:0]    in_wb,
    input  logic [31:0]        in_addr,
    input  logic [31:0]        in_data,
    input  logic [31:0]        in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WB_W-1:0]    out_wb,
    output logic [31:0]        out_result,
    output logic               mreq,
    input  logic               mres,
    output logic [MADDR_W-1:0] maddr,
    output logic [3:0]         mwe,
    output logic [31:0]        mwdata,
    input  logic [31:0]        mrdata,
    output logic               adel,
    output logic               ades,
    output logic [31:0]        epc,
    output logic [31:0]        bad_addr,
    output logic               bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                mreq_q, mreq_d;
    logic [MADDR_W-1:0]  maddr_q, maddr_d;
    logic [3:0]          mwe_q, mwe_d;
    logic [31:0]         mwdata_q, mwdata_d;
    logic                out_valid_q, out_valid_d;
    logic [WB_W-1:0]     out_wb_q, out_wb_d;
    logic [31:0]         out_result_q, out_result_d;
    logic                adel_q, adel_d;
    logic                ades_q, ades_d;
    logic [31:0]         epc_q, epc_d;
    logic [31:0]         bad_addr_q, bad_addr_d;

    // Latched copy of the accepted op, needed while the memory is busy.
    logic                op_read_q, op_read_d;
    logic [1:0]          op_len_q, op_len_d;
    logic                op_uns_q, op_uns_d;
    logic [1:0]          op_off_q, op_off_d;
    logic [WB_W-1:0]     op_wb_q, op_wb_d;
    logic [31:0]         op_data_q, op_data_d;
    logic                squash_q, squash_d;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                bus_err_q, bus_err_d;
    logic [31:0]         op_addr_q, op_addr_d;
    logic [31:0]         op_pc_q, op_pc_d;
`endif

    logic        accept;
    logic        acc_read, acc_write, acc_mem;
    logic        acc_half, acc_word, acc_misaligned;
    logic [3:0]  acc_mwe;
    logic [31:0] acc_mwdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign in_ready = (state_q == ST_IDLE) && !flush;
    assign accept   = in_valid && in_ready;

    // Classify the offered op and precompute its store strobes and lane-replicated data.
    always_comb begin
        acc_read       = in_read;
        acc_write      = in_write && !in_read;
        acc_mem        = acc_read || acc_write;
        acc_half       = (in_len == 2'b01);
        acc_word       = in_len[1];
        acc_misaligned = (acc_half && in_addr[0]) || (acc_word && (in_addr[1:0] != 2'b00));
        acc_mwe        = 4'b0000;
        acc_mwdata     = in_data;
        if (acc_word) begin
            acc_mwe    = 4'b1111;
            acc_mwdata = in_data;
        end else if (acc_half) begin
            acc_mwe    = in_addr[1] ? 4'b1100 : 4'b0011;
            acc_mwdata = {2{in_data[15:0]}};
        end else begin
            acc_mwe    = 4'b0001 << in_addr[1:0];
            acc_mwdata = {4{in_data[7:0]}};
        end
        if (!acc_write) begin
            acc_mwe = 4'b0000;
        end
    end

    // Pick the addressed little-endian lane out of the returned word and extend it.
    always_comb begin
        case (op_off_q)
            2'd1:    ld_byte = mrdata[15:8];
            2'd2:    ld_byte = mrdata[23:16];
            2'd3:    ld_byte = mrdata[31:24];
            default: ld_byte = mrdata[7:0];
        endcase
        ld_half = op_off_q[1] ? mrdata[31:16] : mrdata[15:0];
        case (op_len_q)
            2'b00:   ld_data = {{24{!op_uns_q && ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{!op_uns_q && ld_half[15]}}, ld_half};
            default: ld_data = mrdata;
        endcase
    end

    // Next-state and next-output logic for the IDLE / WAIT / HOLD sequence.
    always_comb begin
        state_d      = state_q;
        mreq_d       = mreq_q;
        maddr_d      = maddr_q;
        mwe_d        = mwe_q;
        mwdata_d     = mwdata_q;
        out_valid_d  = out_valid_q;
        out_wb_d     = out_wb_q;
        out_result_d = out_result_q;
        adel_d       = 1'b0;
        ades_d       = 1'b0;
        epc_d        = epc_q;
        bad_addr_d   = bad_addr_q;
        op_read_d    = op_read_q;
        op_len_d     = op_len_q;
        op_uns_d     = op_uns_q;
        op_off_d     = op_off_q;
        op_wb_d      = op_wb_q;
        op_data_d    = op_data_q;
        squash_d     = squash_q;
`ifdef MEM_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        bus_err_d    = 1'b0;
        op_addr_d    = op_addr_q;
        op_pc_d      = op_pc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_read_d = acc_read;
                    op_len_d  = in_len;
                    op_uns_d  = in_unsigned;
                    op_off_d  = in_addr[1:0];
                    op_wb_d   = in_wb;
                    op_data_d = in_data;
                    squash_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    tmo_cnt_d = '0;
                    op_addr_d = in_addr;
                    op_pc_d   = in_pc;
`endif
                    if (!acc_mem) begin
                        out_valid_d  = 1'b1;
                        out_result_d = in_data;
                        out_wb_d     = in_wb;
                        state_d      = ST_HOLD;
                    end else if (acc_misaligned) begin
                        adel_d       = acc_read;
                        ades_d       = acc_write;
                        epc_d        = in_pc;
                        bad_addr_d   = in_addr;
                        out_valid_d  = 1'b1;
                        out_result_d = '0;
                        out_wb_d     = '0;
                        state_d      = ST_HOLD;
                    end else begin
                        mreq_d   = 1'b1;
                        maddr_d  = in_addr[MADDR_W+1:2];
                        mwe_d    = acc_mwe;
                        mwdata_d = acc_mwdata;
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    squash_d = 1'b1;
                end
                if (mres) begin
                    mreq_d = 1'b0;
                    mwe_d  = 4'b0000;
                    if (squash_q || flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        out_valid_d  = 1'b1;
                        out_wb_d     = op_wb_q;
                        out_result_d = op_read_q ? ld_data : op_data_q;
                        state_d      = ST_HOLD;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if (tmo_cnt_d == CNT_W'(TIMEOUT)) begin
                        mreq_d     = 1'b0;
                        mwe_d      = 4'b0000;
                        bus_err_d  = 1'b1;
                        epc_d      = op_pc_q;
                        bad_addr_d = op_addr_q;
                        if (squash_q || flush) begin
                            state_d = ST_IDLE;
                        end else begin
                            out_valid_d  = 1'b1;
                            out_wb_d     = '0;
                            out_result_d = '0;
                            state_d      = ST_HOLD;
                        end
                    end
                end
`endif
            end
            ST_HOLD: begin
                if (flush || out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset may strike at any time, even mid-request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mreq_q       <= 1'b0;
            maddr_q      <= '0;
            mwe_q        <= 4'b0000;
            mwdata_q     <= '0;
            out_valid_q  <= 1'b0;
            out_wb_q     <= '0;
            out_result_q <= '0;
            adel_q       <= 1'b0;
            ades_q       <= 1'b0;
            epc_q        <= '0;
            bad_addr_q   <= '0;
            op_read_q    <= 1'b0;
            op_len_q     <= 2'b00;
            op_uns_q     <= 1'b0;
            op_off_q     <= 2'b00;
            op_wb_q      <= '0;
            op_data_q    <= '0;
            squash_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            bus_err_q    <= 1'b0;
            op_addr_q    <= '0;
            op_pc_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            mreq_q       <= mreq_d;
            maddr_q      <= maddr_d;
            mwe_q        <= mwe_d;
            mwdata_q     <= mwdata_d;
            out_valid_q  <= out_valid_d;
            out_wb_q     <= out_wb_d;
            out_result_q <= out_result_d;
            adel_q       <= adel_d;
            ades_q       <= ades_d;
            epc_q        <= epc_d;
            bad_addr_q   <= bad_addr_d;
            op_read_q    <= op_read_d;
            op_len_q     <= op_len_d;
            op_uns_q     <= op_uns_d;
            op_off_q     <= op_off_d;
            op_wb_q      <= op_wb_d;
            op_data_q    <= op_data_d;
            squash_q     <= squash_d;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            bus_err_q    <= bus_err_d;
            op_addr_q    <= op_addr_d;
            op_pc_q      <= op_pc_d;
`endif
        end
    end

    assign mreq       = mreq_q;
    assign maddr      = maddr_q;
    assign mwe        = mwe_q;
    assign mwdata     = mwdata_q;
    assign out_valid  = out_valid_q;
    assign out_wb     = out_wb_q;
    assign out_result = out_result_q;
    assign adel       = adel_q;
    assign ades       = ades_q;
    assign epc        = epc_q;
    assign bad_addr   = bad_addr_q;
`ifdef MEM_TIMEOUT_EN
    assign bus_err    = bus_err_q;
`else
    assign bus_err    = 1'b0;
`endif

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Clocked, handshaked memory-access pipeline stage sitting between EXE and WB.
- Takes one load/store/pass-through op per transaction. Drives a word-addressed data memory with a req/ack handshake.
- Performs byte-lane steering, sign/zero extension and alignment checking (adel/ades), then presents a registered result to WB.
- Parametrised successor of the combinational MEM stage: multi-cycle memory latency, back-pressure, flush, optional bus timeout.

Parameters:
- WB_W, 11, width of write-back control bits passed through untouched
- MADDR_W, 8, memory word-address width (maddr = addr[MADDR_W+1:2])
- TIMEOUT, 16, cycles to wait for mres before abort (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  EXE offers an op
- in_ready  out  1  stage accepts op this cycle
- in_read  in  1  load op
- in_write  in  1  store op (read and write both 1 is illegal; treat as read)
- in_len  in  2  00 byte, 01 half, 10 word, 11 treated as word
- in_unsigned  in  1  zero-extend loads
- in_wb  in  WB_W  write-back control passthrough
- in_addr  in  32  effective address
- in_data  in  32  store data / EXE result for non-memory ops
- in_pc  in  32  PC of op, for epc
- flush  in  1  discard the op in the stage
- out_valid  out  1  result available to WB
- out_ready  in  1  WB consumes result
- out_wb  out  WB_W  passthrough; all-zero (NOP) on exception/flush/timeout
- out_result  out  32  load data or EXE result
- mreq  out  1  memory request
- mres  in  1  memory acknowledge (one-cycle pulse)
- maddr  out  MADDR_W  memory word address
- mwe  out  4  byte write strobes (0 for loads)
- mwdata  out  32  lane-replicated store data
- mrdata  in  32  load data, valid when mres=1
- adel  out  1  load address error, one-cycle pulse
- ades  out  1  store address error, one-cycle pulse
- epc  out  32  PC of faulting op, held until next exception
- bad_addr  out  32  faulting address, held until next exception
- bus_err  out  1  timeout abort pulse (0 without MEM_TIMEOUT_EN)

Behaviour:

States:
- IDLE, WAIT (mreq high), HOLD (out_valid high).

Handshake and acceptance:
- in_ready = (state==IDLE) && !flush.
- Op is accepted on in_valid && in_ready; all inputs are latched on acceptance.

Accepted op in IDLE:
- Non-memory op (read=write=0): next cycle out_valid=1, out_result=in_data, out_wb=in_wb; go HOLD. Latency 1.
- Misaligned op (half with addr[0]=1; word with addr[1:0]!=0): next cycle adel (read) or ades (write) pulses for 1 cycle; epc/bad_addr load; out_valid=1 with out_wb=0; no mreq; go HOLD.
- Aligned memory op: next cycle mreq=1 with maddr/mwe/mwdata stable; go WAIT.

Store lane steering:
- byte: mwe = 0001 << addr[1:0], mwdata = {4{d[7:0]}}.
- half: mwe = addr[1] ? 1100 : 0011, mwdata = {2{d[15:0]}}.
- word: mwe = 1111.

WAIT:
- mreq and all memory outputs are held until mres is sampled high.
- On mres: mreq drops the same edge and the load result is latched.
- Load extraction is little-endian: byte lane addr[1:0], half lane addr[1], extension per in_unsigned.
- Store result = in_data (out_wb passthrough).
- Next cycle: out_valid=1, state HOLD.

HOLD:
- out_valid and outputs are held stable until out_ready; then go IDLE.
- No new op is accepted in the same cycle (minimum 2 cycles per op).

Flush:
- In IDLE: blocks acceptance.
- In WAIT: mreq must remain until mres (bus transactions cannot be aborted). The op is marked squashed; on mres return to IDLE with no out_valid.
- In HOLD: out_valid drops next cycle; go IDLE.
- Exceptions are not raised for an op flushed in the same cycle it is accepted, since acceptance is blocked.

Spurious ack:
- mres while mreq=0 is ignored.

Reset:
- Asynchronous, any time, including mid-WAIT.
- State=IDLE; mreq, out_valid, adel, ades, bus_err, mwe = 0; epc, bad_addr, out_result, out_wb, maddr, mwdata = 0.

Optional Feature:
- MEM_TIMEOUT_EN defined: a counter of width $clog2(TIMEOUT+1) clears on entry to WAIT and increments each WAIT cycle without mres.
  - When it reaches TIMEOUT: mreq drops, bus_err pulses 1 cycle, bad_addr/epc load.
  - Unflushed op then presents out_valid with out_wb=0; flushed op returns to IDLE.
  - mres on the same cycle as the timeout wins: normal completion.
- Undefined: no counter; WAIT persists indefinitely; bus_err tied 0.

Test Plan:
- Load byte, addr=0x00000013, unsigned=0, mrdata=0x80FF7F00, mres 3 cycles after mreq -> maddr=0x04, mwe=0000, out_result=0x FFFFFF80, out_valid 1 cycle after mres, held while out_ready=0.
- Store half, addr=0x22, in_data=0x0000BEEF -> mreq with maddr=0x08, mwe=1100, mwdata=0xBEEFBEEF; out_wb=in_wb after mres.
- Load word, addr=0x102, pc=0x400 -> adel pulse, epc=0x400, bad_addr=0x102, mreq never asserted, out_valid with out_wb=0.
- Flush asserted during WAIT -> mreq stays until mres, no out_valid, in_ready returns next cycle; reset asserted mid-WAIT -> mreq=0 immediately (async), state IDLE.
- Non-memory op, in_data=0x12345678, out_ready=1 -> out_result=0x12345678 one cycle after acceptance; back-to-back ops accepted every 2 cycles.
- MEM_TIMEOUT_EN, TIMEOUT=16, mres never returned -> mreq drops after 16 WAIT cycles, bus_err single pulse, out_wb=0; mres on cycle 16 -> normal completion, no bus_err.
